// File: rtl/tmds_rst_pkg.sv
// Shared types and constants for the TMDS PLL-lock reset sequencer.
package tmds_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2,
        REINIT    = 2'd3
    } state_e;

    localparam int                 RELOCK_W   = 8;
    localparam logic [RELOCK_W-1:0] RELOCK_SAT = 8'd255;

    // Largest of three cycle counts; sizes the shared state timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchroniser, asynchronous active-high reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops give the first stage a cycle to settle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tmds_rst_seq.sv
// PLL-lock qualification and reset sequencer for the TMDS pixel/serialiser
// logic. Runs on the free-running init clock.
// Optional feature: define TMDS_RST_SEQ_REINIT_EN to build the REINIT state
// (PLL re-init pulse after a lock timeout). Without it WAIT_LOCK waits forever
// and pll_reinit is tied low.
module tmds_rst_seq
    import tmds_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYC   = 50000,
    parameter int LOSS_FILT_CYC     = 16,
    parameter int RETRY_TIMEOUT_CYC = 500000,
    parameter int RST_HOLD_CYC      = 32
) (
    input  logic                init_clk,
    input  logic                reset,
    input  logic                pll_lock,
    output logic                pll_reinit,
    output logic                sys_rst,
    output logic                locked,
    output logic [RELOCK_W-1:0] relock_cnt
);

    localparam int TMR_MAX = max3(RETRY_TIMEOUT_CYC, LOCK_STABLE_CYC, RST_HOLD_CYC);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int FLT_W   = (LOSS_FILT_CYC > 1) ? $clog2(LOSS_FILT_CYC) : 1;

    logic                lock_s;
    state_e              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [FLT_W-1:0]    filt_q, filt_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                sys_rst_q, locked_q;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i (init_clk),
        .rst_i (reset),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    // Next-state logic; the shared timer restarts on every state change.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        filt_d   = '0;
        relock_d = relock_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end
`ifdef TMDS_RST_SEQ_REINIT_EN
                else if (timer_q == TMR_W'(RETRY_TIMEOUT_CYC - 1)) begin
                    state_d = REINIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer_q == TMR_W'(LOCK_STABLE_CYC - 1)) begin
                    state_d = RUN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RUN: begin
                // Short lock_s drops are filtered; filter clears on any high.
                if (!lock_s) begin
                    if (filt_q == FLT_W'(LOSS_FILT_CYC - 1)) begin
                        state_d = WAIT_LOCK;
                        if (relock_q != RELOCK_SAT) begin
                            relock_d = relock_q + 1'b1;
                        end
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
            end
`ifdef TMDS_RST_SEQ_REINIT_EN
            REINIT: begin
                // lock_s deliberately ignored while the PLL is being re-inited.
                if (timer_q == TMR_W'(RST_HOLD_CYC - 1)) begin
                    state_d = WAIT_LOCK;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // State, counters and outputs decoded from the next state.
    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_LOCK;
            timer_q   <= '0;
            filt_q    <= '0;
            relock_q  <= '0;
            sys_rst_q <= 1'b1;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            filt_q    <= filt_d;
            relock_q  <= relock_d;
            sys_rst_q <= (state_d != RUN);
            locked_q  <= (state_d == RUN);
        end
    end

`ifdef TMDS_RST_SEQ_REINIT_EN
    logic reinit_q;

    // Re-init request is high for exactly the REINIT residency.
    always_ff @(posedge init_clk or posedge reset) begin
        if (reset) begin
            reinit_q <= 1'b0;
        end else begin
            reinit_q <= (state_d == REINIT);
        end
    end

    assign pll_reinit = reinit_q;
`else
    assign pll_reinit = 1'b0;
`endif

    assign sys_rst    = sys_rst_q;
    assign locked     = locked_q;
    assign relock_cnt = relock_q;

endmodule

// File: tb/tb_tmds_rst_seq.sv
// Directed bench for tmds_rst_seq (LOCK_STABLE=8, LOSS_FILT=4,
// RETRY_TIMEOUT=64, RST_HOLD=5).
module tb_tmds_rst_seq;

    logic       init_clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reinit;
    logic       sys_rst;
    logic       locked;
    logic [7:0] relock_cnt;

    int total = 0;
    int bad   = 0;

    tmds_rst_seq #(
        .LOCK_STABLE_CYC   (8),
        .LOSS_FILT_CYC     (4),
        .RETRY_TIMEOUT_CYC (64),
        .RST_HOLD_CYC      (5)
    ) dut (
        .init_clk   (init_clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .pll_reinit (pll_reinit),
        .sys_rst    (sys_rst),
        .locked     (locked),
        .relock_cnt (relock_cnt)
    );

    always #5 init_clk = ~init_clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge init_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_locked(input logic exp, input int bound, input string tag);
        int n;
        n = 0;
        while (locked !== exp && n < bound) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, locked}, {31'd0, exp});
    endtask

    initial begin
        logic       exp_r;
        logic [7:0] exp_rl;

        reset    = 1'b1;
        pll_lock = 1'b0;
        step(3);
        chk("rst_sys_rst", {31'd0, sys_rst}, 1);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_reinit", {31'd0, pll_reinit}, 0);
        chk("rst_relock", {24'd0, relock_cnt}, 0);

        // Clean lock: pll_lock high from edge k=10, release at edge k+11.
        reset = 1'b0;
        step(10);
        pll_lock = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            chk("acq_locked_lo", {31'd0, locked}, 0);
            chk("acq_sys_rst_hi", {31'd0, sys_rst}, 1);
            chk("acq_reinit", {31'd0, pll_reinit}, 0);
        end
        step(1);
        chk("acq_locked", {31'd0, locked}, 1);
        chk("acq_sys_rst", {31'd0, sys_rst}, 0);
        chk("acq_reinit_end", {31'd0, pll_reinit}, 0);
        chk("acq_relock", {24'd0, relock_cnt}, 0);

        // RUN glitch of 3 cycles: nothing changes.
        step(2);
        pll_lock = 1'b0;
        step(3);
        pll_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("glitch_locked", {31'd0, locked}, 1);
            chk("glitch_sys_rst", {31'd0, sys_rst}, 0);
            chk("glitch_relock", {24'd0, relock_cnt}, 0);
        end

        // Sustained loss from edge k: outputs change at edge k+6.
        pll_lock = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk("loss_still_locked", {31'd0, locked}, 1);
        end
        step(1);
        chk("loss_locked", {31'd0, locked}, 0);
        chk("loss_sys_rst", {31'd0, sys_rst}, 1);
        chk("loss_relock", {24'd0, relock_cnt}, 1);

        // STABLE chatter: lock from edge j, 1-cycle drop after j+5.
        // STABLE at j+3, restart at j+9, release at j+17 (not j+11).
        pll_lock = 1'b1;
        step(5);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        for (int i = 6; i <= 16; i++) begin
            chk("chat_locked_lo", {31'd0, locked}, 0);
            chk("chat_sys_rst_hi", {31'd0, sys_rst}, 1);
            step(1);
        end
        chk("chat_locked", {31'd0, locked}, 1);
        chk("chat_sys_rst", {31'd0, sys_rst}, 0);
        chk("chat_relock", {24'd0, relock_cnt}, 1);

        // Asynchronous reset between edges while in RUN.
        step(2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_sys_rst", {31'd0, sys_rst}, 1);
        chk("arst_locked", {31'd0, locked}, 0);
        chk("arst_relock", {24'd0, relock_cnt}, 0);
        chk("arst_reinit", {31'd0, pll_reinit}, 0);
        pll_lock = 1'b0;
        step(2);

        // Never locks: WAIT_LOCK entered at the release; pulses at 64..68, 133..137.
        reset = 1'b0;
        for (int t = 1; t <= 140; t++) begin
            step(1);
`ifdef TMDS_RST_SEQ_REINIT_EN
            exp_r = ((t >= 64 && t <= 68) || (t >= 133 && t <= 137)) ? 1'b1 : 1'b0;
`else
            exp_r = 1'b0;
`endif
            chk($sformatf("nolock_reinit_t%0d", t), {31'd0, pll_reinit}, {31'd0, exp_r});
            chk("nolock_locked", {31'd0, locked}, 0);
        end

        // Saturation: 260 loss/re-lock cycles.
        exp_rl = 8'd0;
        for (int it = 1; it <= 260; it++) begin
            pll_lock = 1'b1;
            wait_locked(1'b1, 300, "sat_lock");
            pll_lock = 1'b0;
            wait_locked(1'b0, 50, "sat_loss");
            if (exp_rl != 8'd255) exp_rl = exp_rl + 8'd1;
            chk($sformatf("sat_relock_%0d", it), {24'd0, relock_cnt}, {24'd0, exp_rl});
        end
        step(10);
        chk("sat_hold", {24'd0, relock_cnt}, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
